mem_port_arbiter: RTL and testbench
===================================

Name: mem_port_arbiter

Overview:
Round-robin arbiter that shares one single-ported data-memory interface between NUM_REQ requesters, e.g. instruction fetch (req 0) and load/store unit (req 1) in the single-cycle core's multi-cycle memory variant. It accepts one request at a time and holds the selected command stable on the memory port until the memory acknowledges. It then routes the acknowledge and read data back to the owning requester. Grant is fair: the last served requester gets lowest priority next.

Parameters:
NUM_REQ, 2, number of requesters (2..8)
ADDR_W, 32, address width
DATA_W, 32, data width

Ports:
i_clk  in  1  clock, all state updates on rising edge
i_reset  in  1  synchronous active-high reset
i_req  in  NUM_REQ  per-requester request, held high until granted
i_addr  in  NUM_REQ*ADDR_W  per-requester address, requester k at bits [k*ADDR_W +: ADDR_W]
i_wen  in  NUM_REQ  per-requester write enable (1 = write, 0 = read)
i_wdata  in  NUM_REQ*DATA_W  per-requester write data, same packing as i_addr
o_gnt  out  NUM_REQ  one-hot grant pulse; command captured this cycle
o_done  out  NUM_REQ  one-hot completion pulse to the owner
o_rdata  out  DATA_W  read data, valid while o_done is nonzero
o_mem_req  out  1  memory request
o_mem_addr  out  ADDR_W  registered command address
o_mem_wen  out  1  registered command write enable
o_mem_wdata  out  DATA_W  registered command write data
i_mem_ack  in  1  memory completion, single-cycle pulse
i_mem_rdata  in  DATA_W  memory read data, valid with i_mem_ack
o_busy  out  1  transaction in flight
o_err  out  1  sticky error flag: acknowledge received with no transaction in flight

Behaviour:
- FSM with 2 states: IDLE, BUSY. Registered state: owner index, RR pointer ptr, command registers, err.
- Reset (synchronous): state=IDLE, ptr=0, owner=0, command regs=0, o_err=0. All outputs read 0 in the cycle after reset is sampled.
- IDLE: winner = first k with i_req[k]=1, scanning ptr, ptr+1, ..., wrapping mod NUM_REQ.
  - If any request: o_gnt[winner]=1 combinationally in this cycle. On the clock edge, capture i_addr/i_wen/i_wdata of winner into command regs, set owner=winner, go to BUSY.
  - If no request: o_gnt=0 and the FSM stays in IDLE.
- BUSY: o_mem_req=1 and o_busy=1. o_mem_addr/wen/wdata come from the command regs and stay stable until ack. o_gnt=0; new requests wait.
  - On i_mem_ack=1: o_done[owner]=1 combinationally in the same cycle, o_rdata=i_mem_rdata. On the edge, ptr=(owner+1) mod NUM_REQ and state returns to IDLE.
  - o_rdata is 0 when no o_done bit is set. o_rdata is also valid-driven for writes; the requester ignores it.
- Latency: grant at cycle N, o_mem_req from cycle N+1, done in the ack cycle (earliest N+1).
- Throughput: one mandatory IDLE cycle between transactions, so peak rate is 1 transaction per 2 cycles.
- o_mem_req, o_busy, o_mem_* are driven from registered state only. o_gnt and o_done are combinational from state plus inputs.
- Requester contract: hold i_req, addr, wen and wdata stable until o_gnt. Deassert or present the next request after o_gnt. i_req remaining high after grant counts as a new request.
- Spurious ack (i_mem_ack=1 in IDLE): ignored for routing, no o_done, sets o_err=1. Only reset clears o_err.
- Reset mid-BUSY: the transaction is abandoned with no o_done, and the state is IDLE next cycle. The memory is reset on the same signal. Any late ack appears as spurious.
- Simultaneous requests: exactly one o_gnt bit. Losers see no grant and keep i_req high.
- Pointer wrap: after owner=NUM_REQ-1, ptr=0.

Test Plan:
- Single read: reset, i_req=01, addr0=0x100, wen0=0, ack 3 cycles later with rdata=0xDEADBEEF -> o_gnt=01 at cycle 0. o_mem_req=1 with o_mem_addr=0x100 during cycles 1-3. o_done=01 and o_rdata=0xDEADBEEF at cycle 3. o_busy=0 at cycle 4.
- Fairness: i_req=11 held continuously, ack 1 cycle after each req -> grants alternate 01, 10, 01, 10 on every IDLE cycle, starting with 01 after reset.
- Write routing: req 1 writes addr=0x2004, wdata=0x12345678 -> o_mem_wen=1 and command stable until ack. o_done=10, with no o_done bit for req 0.
- Command stability: change i_addr/i_wdata of the owner during BUSY -> o_mem_addr and o_mem_wdata remain the captured values.
- Spurious ack: pulse i_mem_ack in IDLE -> o_err=1 and o_done=00. o_err stays 1 through later transactions until reset.
- Reset mid-transaction: assert i_reset during BUSY -> next cycle o_mem_req=0, state IDLE, ptr=0. A following i_req=11 grants 01.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one single-ported memory between NUM_REQ requesters.
// One transaction in flight; command is registered and held until the memory acks.
module mem_port_arbiter #(
  parameter int NUM_REQ = 2,
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32
) (
  input  logic                      i_clk,
  input  logic                      i_reset,
  input  logic [NUM_REQ-1:0]        i_req,
  input  logic [NUM_REQ*ADDR_W-1:0] i_addr,
  input  logic [NUM_REQ-1:0]        i_wen,
  input  logic [NUM_REQ*DATA_W-1:0] i_wdata,
  output logic [NUM_REQ-1:0]        o_gnt,
  output logic [NUM_REQ-1:0]        o_done,
  output logic [DATA_W-1:0]         o_rdata,
  output logic                      o_mem_req,
  output logic [ADDR_W-1:0]         o_mem_addr,
  output logic                      o_mem_wen,
  output logic [DATA_W-1:0]         o_mem_wdata,
  input  logic                      i_mem_ack,
  input  logic [DATA_W-1:0]         i_mem_rdata,
  output logic                      o_busy,
  output logic                      o_err
);

  localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef enum logic {IDLE, BUSY} state_t;

  state_t              state_q, state_d;
  logic [IW-1:0]       owner_q, owner_d;
  logic [IW-1:0]       ptr_q, ptr_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic                wen_q, wen_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic                err_q, err_d;

  logic [IW-1:0]       win;
  logic                found;
  logic [IW:0]         idx;

  // First requester at or after ptr, wrapping modulo NUM_REQ
  always_comb begin
    win   = '0;
    found = 1'b0;
    idx   = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      idx = {1'b0, ptr_q} + (IW+1)'(i);
      if (idx >= (IW+1)'(NUM_REQ)) idx = idx - (IW+1)'(NUM_REQ);
      if (!found && i_req[idx[IW-1:0]]) begin
        found = 1'b1;
        win   = idx[IW-1:0];
      end
    end
  end

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    ptr_d   = ptr_q;
    addr_d  = addr_q;
    wen_d   = wen_q;
    wdata_d = wdata_q;
    err_d   = err_q;
    o_gnt   = '0;
    o_done  = '0;
    o_rdata = '0;
    unique case (state_q)
      IDLE: begin
        if (i_mem_ack) err_d = 1'b1;
        if (found) begin
          o_gnt[win] = 1'b1;
          state_d    = BUSY;
          owner_d    = win;
          addr_d     = i_addr[win*ADDR_W +: ADDR_W];
          wen_d      = i_wen[win];
          wdata_d    = i_wdata[win*DATA_W +: DATA_W];
        end
      end
      BUSY: begin
        if (i_mem_ack) begin
          o_done[owner_q] = 1'b1;
          o_rdata         = i_mem_rdata;
          state_d         = IDLE;
          ptr_d = (owner_q == IW'(NUM_REQ-1)) ? '0 : owner_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q <= IDLE;
      owner_q <= '0;
      ptr_q   <= '0;
      addr_q  <= '0;
      wen_q   <= 1'b0;
      wdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      ptr_q   <= ptr_d;
      addr_q  <= addr_d;
      wen_q   <= wen_d;
      wdata_q <= wdata_d;
      err_q   <= err_d;
    end
  end

  assign o_mem_req   = (state_q == BUSY);
  assign o_busy      = (state_q == BUSY);
  assign o_mem_addr  = addr_q;
  assign o_mem_wen   = wen_q;
  assign o_mem_wdata = wdata_q;
  assign o_err       = err_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed vectors, grant/done checked
// by a negedge monitor against expectation queues.
module tb_mem_port_arbiter;

  logic        i_clk = 1'b0;
  logic        i_reset;
  logic [1:0]  i_req;
  logic [63:0] i_addr;
  logic [1:0]  i_wen;
  logic [63:0] i_wdata;
  logic [1:0]  o_gnt;
  logic [1:0]  o_done;
  logic [31:0] o_rdata;
  logic        o_mem_req;
  logic [31:0] o_mem_addr;
  logic        o_mem_wen;
  logic [31:0] o_mem_wdata;
  logic        i_mem_ack;
  logic [31:0] i_mem_rdata;
  logic        o_busy;
  logic        o_err;

  int n_vec = 0;
  int n_err = 0;

  logic [1:0]  gnt_q[$];
  logic [33:0] done_q[$];

  mem_port_arbiter #(.NUM_REQ(2), .ADDR_W(32), .DATA_W(32)) dut (
    .i_clk(i_clk), .i_reset(i_reset), .i_req(i_req), .i_addr(i_addr),
    .i_wen(i_wen), .i_wdata(i_wdata), .o_gnt(o_gnt), .o_done(o_done),
    .o_rdata(o_rdata), .o_mem_req(o_mem_req), .o_mem_addr(o_mem_addr),
    .o_mem_wen(o_mem_wen), .o_mem_wdata(o_mem_wdata),
    .i_mem_ack(i_mem_ack), .i_mem_rdata(i_mem_rdata),
    .o_busy(o_busy), .o_err(o_err)
  );

  always #5 i_clk = ~i_clk;

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  always @(negedge i_clk) begin
    if (i_reset === 1'b0) begin
      if (o_gnt !== 2'b00) begin
        if (gnt_q.size() == 0) begin
          n_vec++;
          n_err++;
          $display("FAIL gnt_unexpected: got %b expected none", o_gnt);
        end else begin
          chk("gnt", {62'd0, o_gnt}, {62'd0, gnt_q.pop_front()});
        end
      end
      if (o_done !== 2'b00) begin
        if (done_q.size() == 0) begin
          n_vec++;
          n_err++;
          $display("FAIL done_unexpected: got %b expected none", o_done);
        end else begin
          chk("done_rdata", {30'd0, o_done, o_rdata},
              {30'd0, done_q.pop_front()});
        end
      end
    end
  end

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic do_reset();
    i_reset = 1'b1;
    tick();
    i_reset = 1'b0;
  endtask

  initial begin
    i_reset     = 1'b1;
    i_req       = '0;
    i_addr      = '0;
    i_wen       = '0;
    i_wdata     = '0;
    i_mem_ack   = 1'b0;
    i_mem_rdata = '0;
    tick();
    do_reset();

    chk("rst_busy", {63'd0, o_busy}, 64'd0);
    chk("rst_mem_req", {63'd0, o_mem_req}, 64'd0);
    chk("rst_addr", {32'd0, o_mem_addr}, 64'd0);
    chk("rst_err", {63'd0, o_err}, 64'd0);
    chk("rst_done", {62'd0, o_done}, 64'd0);

    // single read by requester 0
    i_req        = 2'b01;
    i_addr[31:0] = 32'h100;
    i_wen        = 2'b00;
    gnt_q.push_back(2'b01);
    tick();
    i_req = 2'b00;
    for (int c = 1; c <= 3; c++) begin
      chk("rd_mem_req", {63'd0, o_mem_req}, 64'd1);
      chk("rd_mem_addr", {32'd0, o_mem_addr}, 64'h100);
      if (c == 3) begin
        i_mem_ack   = 1'b1;
        i_mem_rdata = 32'hDEADBEEF;
        done_q.push_back({2'b01, 32'hDEADBEEF});
      end
      tick();
    end
    i_mem_ack   = 1'b0;
    i_mem_rdata = '0;
    chk("rd_busy_after", {63'd0, o_busy}, 64'd0);

    // fairness: both requesting continuously
    do_reset();
    i_addr = {32'hB000, 32'hA000};
    i_req  = 2'b11;
    for (int t = 0; t < 4; t++) begin
      gnt_q.push_back((t % 2 == 0) ? 2'b01 : 2'b10);
      tick();
      chk("fair_addr", {32'd0, o_mem_addr},
          (t % 2 == 0) ? 64'hA000 : 64'hB000);
      i_mem_ack   = 1'b1;
      i_mem_rdata = 32'h5000 + t;
      done_q.push_back({((t % 2 == 0) ? 2'b01 : 2'b10), 32'h5000 + t});
      tick();
      i_mem_ack = 1'b0;
    end
    i_req = 2'b00;
    tick();

    // write by requester 1, then disturb its inputs while busy
    i_req          = 2'b10;
    i_addr[63:32]  = 32'h2004;
    i_wen          = 2'b10;
    i_wdata[63:32] = 32'h12345678;
    gnt_q.push_back(2'b10);
    tick();
    i_req = 2'b00;
    chk("wr_wen", {63'd0, o_mem_wen}, 64'd1);
    chk("wr_addr", {32'd0, o_mem_addr}, 64'h2004);
    chk("wr_wdata", {32'd0, o_mem_wdata}, 64'h12345678);
    i_addr[63:32]  = 32'hFFFF;
    i_wdata[63:32] = 32'h0;
    i_wen          = 2'b00;
    tick();
    chk("stab_addr", {32'd0, o_mem_addr}, 64'h2004);
    chk("stab_wdata", {32'd0, o_mem_wdata}, 64'h12345678);
    chk("stab_wen", {63'd0, o_mem_wen}, 64'd1);
    i_mem_ack   = 1'b1;
    i_mem_rdata = 32'hAAAA5555;
    done_q.push_back({2'b10, 32'hAAAA5555});
    tick();
    i_mem_ack = 1'b0;

    // spurious ack while idle
    i_mem_ack   = 1'b1;
    i_mem_rdata = 32'hBAD;
    #2;
    chk("spur_done", {62'd0, o_done}, 64'd0);
    chk("spur_rdata", {32'd0, o_rdata}, 64'd0);
    tick();
    i_mem_ack = 1'b0;
    chk("spur_err", {63'd0, o_err}, 64'd1);

    // err stays set across a full transaction
    i_req        = 2'b01;
    i_addr[31:0] = 32'h300;
    gnt_q.push_back(2'b01);
    tick();
    i_req       = 2'b00;
    i_mem_ack   = 1'b1;
    i_mem_rdata = 32'h77;
    done_q.push_back({2'b01, 32'h77});
    tick();
    i_mem_ack = 1'b0;
    tick();
    chk("err_sticky", {63'd0, o_err}, 64'd1);

    // reset in the middle of a transaction; ptr currently 1
    i_req = 2'b10;
    gnt_q.push_back(2'b10);
    tick();
    i_req = 2'b00;
    chk("mid_mem_req", {63'd0, o_mem_req}, 64'd1);
    do_reset();
    chk("mid_rst_req", {63'd0, o_mem_req}, 64'd0);
    chk("mid_rst_busy", {63'd0, o_busy}, 64'd0);
    chk("mid_rst_err", {63'd0, o_err}, 64'd0);
    i_req = 2'b11;
    gnt_q.push_back(2'b01);
    tick();
    i_req       = 2'b00;
    i_mem_ack   = 1'b1;
    i_mem_rdata = 32'h99;
    done_q.push_back({2'b01, 32'h99});
    tick();
    i_mem_ack = 1'b0;
    tick();

    chk("gnt_q_drained", 64'(gnt_q.size()), 64'd0);
    chk("done_q_drained", 64'(done_q.size()), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
